// File: rtl/ifetch_buf_pkg.sv
// Shared widths for the instruction-fetch buffer and its queue.
package ifetch_buf_pkg;
  localparam int ADDR_W    = 16;
  localparam int WORD_W    = 32;
  localparam int DEPTH_DEF = 4;
endpackage

// File: rtl/ifq_fifo.sv
// First-word fall-through queue of {instruction, pc} entries with flush and occupancy.
module ifq_fifo import ifetch_buf_pkg::*; #(
  parameter int W     = WORD_W + ADDR_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_occ
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   OCC_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   OCC_FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_occ;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && (r_occ != OCC_FULL);
  assign w_pop  = i_pop && (r_occ != '0);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_occ <= r_occ + OCC_ONE;
      else if (!w_push && w_pop) r_occ <= r_occ - OCC_ONE;
    end
  end

  // Storage carries no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_valid = (r_occ != '0);
  assign o_occ   = r_occ;
endmodule

// File: rtl/ifetch_buf.sv
// Instruction fetch front end: PC, one-deep inflight tracking with branch squash,
// credit-checked issue into a FWFT fetch queue.
module ifetch_buf import ifetch_buf_pkg::*; #(
  parameter int              ADDR     = ADDR_W,
  parameter int              WORD     = WORD_W,
  parameter int              DEPTH    = DEPTH_DEF,
  parameter logic [ADDR-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    v_i,
  input  logic                    stall_i,
  input  logic                    branch_i,
  input  logic [ADDR-1:0]         target_i,
  output logic [ADDR-1:0]         addr_o,
  output logic                    req_o,
  input  logic [WORD-1:0]         inst_i,
  output logic                    v_o,
  output logic [WORD-1:0]         inst_o,
  output logic [ADDR-1:0]         pc_o,
  output logic [$clog2(DEPTH):0]  occ_o
);
  logic [ADDR-1:0]        r_pc;
  logic [ADDR-1:0]        r_infl_pc;
  logic                   r_infl;
  logic [$clog2(DEPTH):0] w_occ;
  logic                   w_v;
  logic                   w_credit;
  logic                   w_issue;
  logic                   w_push;
  logic                   w_pop;
  logic [WORD+ADDR-1:0]   w_head;

  // A dequeue in this cycle is deliberately not counted as free space.
  assign w_credit = (int'(w_occ) + int'(r_infl)) < DEPTH;
  assign w_issue  = rst && v_i && !branch_i && w_credit;
  assign w_push   = r_infl && !branch_i;
  assign w_pop    = w_v && !stall_i && !branch_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= RESET_PC;
      r_infl    <= 1'b0;
      r_infl_pc <= '0;
    end else begin
      if (branch_i)     r_pc <= target_i;
      else if (w_issue) r_pc <= r_pc + ADDR'(1);
      r_infl <= w_issue;
      if (w_issue) r_infl_pc <= r_pc;
    end
  end

  ifq_fifo #(
    .W     (WORD + ADDR),
    .DEPTH (DEPTH)
  ) u_ifq (
    .clk     (clk),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (branch_i),
    .i_din   ({inst_i, r_infl_pc}),
    .o_dout  (w_head),
    .o_valid (w_v),
    .o_occ   (w_occ)
  );

  assign addr_o = r_pc;
  assign req_o  = w_issue;
  assign v_o    = w_v;
  assign inst_o = w_head[WORD+ADDR-1:ADDR];
  assign pc_o   = w_head[ADDR-1:0];
  assign occ_o  = w_occ;
endmodule

// File: tb/tb_ifetch_buf.sv
// Directed bench for ifetch_buf: vector table plus multi-cycle sequences; memory returns 0x100+addr.
module tb_ifetch_buf;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [15:0] target_i = '0;
  logic [31:0] inst_i = '0;
  logic [31:0] inst2_i = '0;
  logic [15:0] addr_o, pc_o, addr2_o, pc2_o;
  logic        req_o, v_o, req2_o, v2_o;
  logic [31:0] inst_o, inst2_o;
  logic [2:0]  occ_o, occ2_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic        last_req = 1'b0, last_req2 = 1'b0;
  logic [15:0] last_addr = '0, last_addr2 = '0;

  always #5 clk = ~clk;

  ifetch_buf #(.ADDR(16), .WORD(32), .DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .v_i(v_i), .stall_i(stall_i), .branch_i(branch_i),
    .target_i(target_i), .addr_o(addr_o), .req_o(req_o), .inst_i(inst_i),
    .v_o(v_o), .inst_o(inst_o), .pc_o(pc_o), .occ_o(occ_o)
  );

  ifetch_buf #(.ADDR(16), .WORD(32), .DEPTH(4), .RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .rst(rst), .v_i(v_i), .stall_i(stall_i), .branch_i(branch_i),
    .target_i(target_i), .addr_o(addr2_o), .req_o(req2_o), .inst_i(inst2_i),
    .v_o(v2_o), .inst_o(inst2_o), .pc_o(pc2_o), .occ_o(occ2_o)
  );

  typedef struct {
    logic r, v, s, b;
    logic [15:0] t;
    logic [15:0] addr;
    logic req, vo;
    logic [31:0] inst;
    logic [15:0] pc;
    logic [2:0] occ;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, v, s, b, input logic [15:0] t,
                              input logic [15:0] addr, input logic req, vo,
                              input logic [31:0] inst, input logic [15:0] pc,
                              input logic [2:0] occ);
    vec_t x;
    x.r = r; x.v = v; x.s = s; x.b = b; x.t = t;
    x.addr = addr; x.req = req; x.vo = vo; x.inst = inst; x.pc = pc; x.occ = occ;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs just after the rising edge, check at the falling edge.
  task automatic cyc(input logic r, v, s, b, input logic [15:0] t,
                     input logic [15:0] e_addr, input logic e_req, e_v,
                     input logic [31:0] e_inst, input logic [15:0] e_pc,
                     input logic [2:0] e_occ, input string tag);
    @(posedge clk);
    #1;
    inst_i  = last_req  ? 32'h100 + {16'h0, last_addr}  : 32'hDEADBEEF;
    inst2_i = last_req2 ? 32'h100 + {16'h0, last_addr2} : 32'hDEADBEEF;
    rst = r; v_i = v; stall_i = s; branch_i = b; target_i = t;
    @(negedge clk);
    chk({tag, ".addr"}, 32'(addr_o), 32'(e_addr));
    chk({tag, ".req"},  32'(req_o),  32'(e_req));
    chk({tag, ".v"},    32'(v_o),    32'(e_v));
    chk({tag, ".occ"},  32'(occ_o),  32'(e_occ));
    if (e_v) begin
      chk({tag, ".inst"}, inst_o, e_inst);
      chk({tag, ".pc"},   32'(pc_o), 32'(e_pc));
    end
    $display("%s: addr=%h req=%b v=%b inst=%h pc=%h occ=%0d",
             tag, addr_o, req_o, v_o, inst_o, pc_o, occ_o);
    last_req  = req_o;  last_addr  = addr_o;
    last_req2 = req2_o; last_addr2 = addr2_o;
  endtask

  task automatic rst_cyc(input string tag);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 16'h0, 3'd0, tag);
  endtask

  initial begin
    // Streaming after reset, a mid-run reset, then the stall/fill/drain pattern.
    tbl.push_back(mk(0,1,0,0,16'h0, 16'h0,0,0,32'h0,16'h0,3'd0));
    tbl.push_back(mk(1,1,0,0,16'h0, 16'h0,1,0,32'h0,16'h0,3'd0));
    tbl.push_back(mk(1,1,0,0,16'h0, 16'h1,1,0,32'h0,16'h0,3'd0));
    tbl.push_back(mk(1,1,0,0,16'h0, 16'h2,1,1,32'h100,16'h0,3'd1));
    tbl.push_back(mk(1,1,0,0,16'h0, 16'h3,1,1,32'h101,16'h1,3'd1));
    tbl.push_back(mk(1,1,0,0,16'h0, 16'h4,1,1,32'h102,16'h2,3'd1));
    tbl.push_back(mk(0,1,0,0,16'h0, 16'h0,0,0,32'h0,16'h0,3'd0));
    tbl.push_back(mk(1,1,1,0,16'h0, 16'h0,1,0,32'h0,16'h0,3'd0));
    tbl.push_back(mk(1,1,1,0,16'h0, 16'h1,1,0,32'h0,16'h0,3'd0));
    tbl.push_back(mk(1,1,1,0,16'h0, 16'h2,1,1,32'h100,16'h0,3'd1));
    tbl.push_back(mk(1,1,1,0,16'h0, 16'h3,1,1,32'h100,16'h0,3'd2));
    tbl.push_back(mk(1,1,1,0,16'h0, 16'h4,0,1,32'h100,16'h0,3'd3));
    tbl.push_back(mk(1,1,1,0,16'h0, 16'h4,0,1,32'h100,16'h0,3'd4));
    tbl.push_back(mk(1,1,1,0,16'h0, 16'h4,0,1,32'h100,16'h0,3'd4));
    tbl.push_back(mk(1,1,0,0,16'h0, 16'h4,0,1,32'h100,16'h0,3'd4));
    tbl.push_back(mk(1,1,0,0,16'h0, 16'h4,1,1,32'h101,16'h1,3'd3));
    tbl.push_back(mk(1,1,0,0,16'h0, 16'h5,1,1,32'h102,16'h2,3'd2));
    tbl.push_back(mk(1,1,0,0,16'h0, 16'h6,1,1,32'h103,16'h3,3'd2));
    tbl.push_back(mk(1,1,0,0,16'h0, 16'h7,1,1,32'h104,16'h4,3'd2));
    tbl.push_back(mk(1,1,0,0,16'h0, 16'h8,1,1,32'h105,16'h5,3'd2));

    repeat (2) @(posedge clk);
    foreach (tbl[i])
      cyc(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].b, tbl[i].t, tbl[i].addr, tbl[i].req,
          tbl[i].vo, tbl[i].inst, tbl[i].pc, tbl[i].occ, $sformatf("vec%0d", i));

    // Branch with three queued entries and one response in flight, then branch while v_i=0.
    rst_cyc("br.rst");
    cyc(1,1,1,0,16'h0,  16'h0,1,0,32'h0,16'h0,3'd0, "br.c0");
    cyc(1,1,1,0,16'h0,  16'h1,1,0,32'h0,16'h0,3'd0, "br.c1");
    cyc(1,1,1,0,16'h0,  16'h2,1,1,32'h100,16'h0,3'd1, "br.c2");
    cyc(1,1,1,0,16'h0,  16'h3,1,1,32'h100,16'h0,3'd2, "br.c3");
    cyc(1,1,1,1,16'h40, 16'h4,0,1,32'h100,16'h0,3'd3, "br.b");
    cyc(1,1,0,0,16'h0,  16'h40,1,0,32'h0,16'h0,3'd0, "br.b1");
    cyc(1,1,0,0,16'h0,  16'h41,1,0,32'h0,16'h0,3'd0, "br.b2");
    cyc(1,1,0,0,16'h0,  16'h42,1,1,32'h140,16'h40,3'd1, "br.b3");
    cyc(1,1,0,0,16'h0,  16'h43,1,1,32'h141,16'h41,3'd1, "br.b4");
    cyc(1,0,0,1,16'h80, 16'h44,0,1,32'h142,16'h42,3'd1, "brv0.b");
    cyc(1,0,0,0,16'h0,  16'h80,0,0,32'h0,16'h0,3'd0, "brv0.b1");
    cyc(1,0,0,0,16'h0,  16'h80,0,0,32'h0,16'h0,3'd0, "brv0.b2");

    // Asynchronous reset between edges with two entries queued.
    rst_cyc("ar.rst");
    cyc(1,1,1,0,16'h0, 16'h0,1,0,32'h0,16'h0,3'd0, "ar.c0");
    cyc(1,1,1,0,16'h0, 16'h1,1,0,32'h0,16'h0,3'd0, "ar.c1");
    cyc(1,1,1,0,16'h0, 16'h2,1,1,32'h100,16'h0,3'd1, "ar.c2");
    cyc(1,1,1,0,16'h0, 16'h3,1,1,32'h100,16'h0,3'd2, "ar.c3");
    #2;
    rst = 1'b0;
    #1;
    chk("ar.async.v",    32'(v_o),    32'd0);
    chk("ar.async.occ",  32'(occ_o),  32'd0);
    chk("ar.async.addr", 32'(addr_o), 32'd0);
    chk("ar.async.req",  32'(req_o),  32'd0);
    $display("ar.async: addr=%h req=%b v=%b occ=%0d", addr_o, req_o, v_o, occ_o);
    rst_cyc("ar.hold");
    cyc(1,1,0,0,16'h0, 16'h0,1,0,32'h0,16'h0,3'd0, "ar.rel");

    // v_i dropped after two issues: both responses still delivered in order.
    rst_cyc("vd.rst");
    cyc(1,1,0,0,16'h0, 16'h0,1,0,32'h0,16'h0,3'd0, "vd.c0");
    cyc(1,1,0,0,16'h0, 16'h1,1,0,32'h0,16'h0,3'd0, "vd.c1");
    cyc(1,0,0,0,16'h0, 16'h2,0,1,32'h100,16'h0,3'd1, "vd.c2");
    cyc(1,0,0,0,16'h0, 16'h2,0,1,32'h101,16'h1,3'd1, "vd.c3");
    cyc(1,0,0,0,16'h0, 16'h2,0,0,32'h0,16'h0,3'd0, "vd.c4");

    // PC wrap on the RESET_PC=0xFFFE instance.
    rst_cyc("wr.rst");
    cyc(1,1,0,0,16'h0, 16'h0,1,0,32'h0,16'h0,3'd0, "wr.c0");
    chk("wr.c0.addr2", 32'(addr2_o), 32'hFFFE);
    cyc(1,1,0,0,16'h0, 16'h1,1,0,32'h0,16'h0,3'd0, "wr.c1");
    chk("wr.c1.addr2", 32'(addr2_o), 32'hFFFF);
    cyc(1,1,0,0,16'h0, 16'h2,1,1,32'h100,16'h0,3'd1, "wr.c2");
    chk("wr.c2.v2",    32'(v2_o),  32'd1);
    chk("wr.c2.pc2",   32'(pc2_o), 32'hFFFE);
    chk("wr.c2.inst2", inst2_o,    32'h100FE);
    cyc(1,1,0,0,16'h0, 16'h3,1,1,32'h101,16'h1,3'd1, "wr.c3");
    chk("wr.c3.pc2",   32'(pc2_o), 32'hFFFF);
    chk("wr.c3.inst2", inst2_o,    32'h100FF);
    chk("wr.c3.occ2",  32'(occ2_o), 32'd1);
    cyc(1,1,0,0,16'h0, 16'h4,1,1,32'h102,16'h2,3'd1, "wr.c4");
    chk("wr.c4.pc2",   32'(pc2_o), 32'h0000);
    chk("wr.c4.inst2", inst2_o,    32'h100);
    $display("wr: dut2 pc=%h inst=%h", pc2_o, inst2_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
